// File: rtl/wash_sequencer.sv
// wash_sequencer
//   Program-execution engine for the washing controller. Drives the program
//   ROM address (pc), decodes the 16-bit word {arg[15:8], opcode[7:0]} that the
//   ROM returns in the same cycle, and executes one instruction per clock.
//   It owns the loop counter, the blocking wait timer and the fill, drain and
//   motor run timers. The actuator timers count down on tick regardless of the
//   sequencer state.
//
//   Parameters
//     START_PC        pc loaded on start (words 0-1 hold halt)
//     ERR_ON_ILLEGAL  1: an unknown opcode halts with err; 0: 1-cycle no-op
//
//   Ports
//     clk, rst       clock, asynchronous active-high reset
//     start, abort   1-cycle command pulses (abort wins over everything)
//     tick           timebase enable for all timers
//     instr          instruction word at pc
//     pc             program counter
//     fill_valve, drain_valve, motor_fwd, motor_rev   actuator outputs
//     loop_cnt       loop counter register
//     busy, done, err  status (RUN/WAIT, halted cleanly, illegal opcode seen)
//
//   Build option
//     WASH_DOOR_INTERLOCK_EN adds input door_closed. While it is low the
//     actuator outputs are forced off, timers freeze, execution stalls and
//     start is ignored.
module wash_sequencer #(
  parameter logic [7:0] START_PC       = 8'd2,
  parameter bit         ERR_ON_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        tick,
`ifdef WASH_DOOR_INTERLOCK_EN
  input  logic        door_closed,
`endif
  input  logic [15:0] instr,
  output logic [7:0]  pc,
  output logic        fill_valve,
  output logic        drain_valve,
  output logic        motor_fwd,
  output logic        motor_rev,
  output logic [7:0]  loop_cnt,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [7:0] OP_HALT    = 8'h00;
  localparam logic [7:0] OP_WAIT    = 8'h01;
  localparam logic [7:0] OP_FILL    = 8'h02;
  localparam logic [7:0] OP_RELEASE = 8'h03;
  localparam logic [7:0] OP_FWD     = 8'h04;
  localparam logic [7:0] OP_REV     = 8'h05;
  localparam logic [7:0] OP_SET     = 8'h11;
  localparam logic [7:0] OP_DEC     = 8'h12;
  localparam logic [7:0] OP_JZ      = 8'h21;
  localparam logic [7:0] OP_JNZ     = 8'h22;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_WAIT,
    ST_HALTED
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] loop_cnt_q, loop_cnt_d;
  logic [7:0] wait_tmr_q, wait_tmr_d;
  logic [7:0] fill_tmr_q, fill_tmr_d;
  logic [7:0] drain_tmr_q, drain_tmr_d;
  logic [7:0] motor_tmr_q, motor_tmr_d;
  logic       dir_rev_q, dir_rev_d;
  logic       err_q, err_d;
  logic       fill_valve_q, fill_valve_d;
  logic       drain_valve_q, drain_valve_d;
  logic       motor_fwd_q, motor_fwd_d;
  logic       motor_rev_q, motor_rev_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic [7:0] opcode;
  logic [7:0] arg;
  logic [7:0] pc_inc;
  logic       run_en;
  logic       tick_en;

  assign opcode = instr[7:0];
  assign arg    = instr[15:8];
  assign pc_inc = pc_q + 8'd1;

`ifdef WASH_DOOR_INTERLOCK_EN
  assign run_en = door_closed;
`else
  assign run_en = 1'b1;
`endif
  assign tick_en = tick & run_en;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    loop_cnt_d = loop_cnt_q;
    wait_tmr_d = wait_tmr_q;
    dir_rev_d  = dir_rev_q;
    err_d      = err_q;

    // Free-running actuator countdown; a load below overrides it.
    fill_tmr_d  = (tick_en && fill_tmr_q  != '0) ? fill_tmr_q  - 8'd1 : fill_tmr_q;
    drain_tmr_d = (tick_en && drain_tmr_q != '0) ? drain_tmr_q - 8'd1 : drain_tmr_q;
    motor_tmr_d = (tick_en && motor_tmr_q != '0) ? motor_tmr_q - 8'd1 : motor_tmr_q;

    case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (start && run_en) begin
          pc_d    = START_PC;
          state_d = ST_RUN;
          err_d   = 1'b0;
        end
      end
      ST_WAIT: begin
        if (tick_en) begin
          wait_tmr_d = wait_tmr_q - 8'd1;
          if (wait_tmr_q == 8'd1) begin
            pc_d    = pc_inc;
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (run_en) begin
          case (opcode)
            OP_HALT: state_d = ST_HALTED;
            OP_WAIT: begin
              if (arg == '0) begin
                pc_d = pc_inc;
              end else begin
                wait_tmr_d = arg;
                state_d    = ST_WAIT;
              end
            end
            OP_FILL: begin
              fill_tmr_d  = arg;
              drain_tmr_d = '0;
              pc_d        = pc_inc;
            end
            OP_RELEASE: begin
              drain_tmr_d = arg;
              fill_tmr_d  = '0;
              pc_d        = pc_inc;
            end
            OP_FWD: begin
              motor_tmr_d = arg;
              dir_rev_d   = 1'b0;
              pc_d        = pc_inc;
            end
            OP_REV: begin
              motor_tmr_d = arg;
              dir_rev_d   = 1'b1;
              pc_d        = pc_inc;
            end
            OP_SET: begin
              loop_cnt_d = arg;
              pc_d       = pc_inc;
            end
            OP_DEC: begin
              loop_cnt_d = loop_cnt_q - 8'd1;
              pc_d       = pc_inc;
            end
            OP_JZ:  pc_d = (loop_cnt_q == '0) ? arg : pc_inc;
            OP_JNZ: pc_d = (loop_cnt_q != '0) ? arg : pc_inc;
            default: begin
              if (ERR_ON_ILLEGAL) begin
                state_d     = ST_HALTED;
                err_d       = 1'b1;
                fill_tmr_d  = '0;
                drain_tmr_d = '0;
                motor_tmr_d = '0;
              end else begin
                pc_d = pc_inc;
              end
            end
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d     = ST_IDLE;
      pc_d        = '0;
      loop_cnt_d  = '0;
      wait_tmr_d  = '0;
      fill_tmr_d  = '0;
      drain_tmr_d = '0;
      motor_tmr_d = '0;
      dir_rev_d   = 1'b0;
      err_d       = 1'b0;
    end

    // Outputs are registered from next-state values so they change on the
    // same edge as the state they describe.
    fill_valve_d  = (fill_tmr_d  != '0);
    drain_valve_d = (drain_tmr_d != '0);
    motor_fwd_d   = (motor_tmr_d != '0) && !dir_rev_d;
    motor_rev_d   = (motor_tmr_d != '0) &&  dir_rev_d;
    busy_d        = (state_d == ST_RUN) || (state_d == ST_WAIT);
    done_d        = (state_d == ST_HALTED) && !err_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pc_q          <= '0;
      loop_cnt_q    <= '0;
      wait_tmr_q    <= '0;
      fill_tmr_q    <= '0;
      drain_tmr_q   <= '0;
      motor_tmr_q   <= '0;
      dir_rev_q     <= 1'b0;
      err_q         <= 1'b0;
      fill_valve_q  <= 1'b0;
      drain_valve_q <= 1'b0;
      motor_fwd_q   <= 1'b0;
      motor_rev_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      loop_cnt_q    <= loop_cnt_d;
      wait_tmr_q    <= wait_tmr_d;
      fill_tmr_q    <= fill_tmr_d;
      drain_tmr_q   <= drain_tmr_d;
      motor_tmr_q   <= motor_tmr_d;
      dir_rev_q     <= dir_rev_d;
      err_q         <= err_d;
      fill_valve_q  <= fill_valve_d;
      drain_valve_q <= drain_valve_d;
      motor_fwd_q   <= motor_fwd_d;
      motor_rev_q   <= motor_rev_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign pc          = pc_q;
  assign loop_cnt    = loop_cnt_q;
  assign err         = err_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign fill_valve  = fill_valve_q  & run_en;
  assign drain_valve = drain_valve_q & run_en;
  assign motor_fwd   = motor_fwd_q   & run_en;
  assign motor_rev   = motor_rev_q   & run_en;

endmodule

// File: tb/tb_wash_sequencer.sv
`timescale 1ns/1ps
module tb_wash_sequencer;

  localparam logic [7:0] START_PC       = 8'd2;
  localparam bit         ERR_ON_ILLEGAL = 1'b1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        tick = 1'b0;
  logic [15:0] instr;
  logic [7:0]  pc;
  logic [7:0]  loop_cnt;
  logic        fill_valve, drain_valve, motor_fwd, motor_rev, busy, done, err;
  logic [15:0] rom [256];
`ifdef WASH_DOOR_INTERLOCK_EN
  logic        door_closed = 1'b1;
`endif

  int tests  = 0;
  int failed = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  assign instr = rom[pc];

  wash_sequencer #(
    .START_PC       (START_PC),
    .ERR_ON_ILLEGAL (ERR_ON_ILLEGAL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .tick        (tick),
`ifdef WASH_DOOR_INTERLOCK_EN
    .door_closed (door_closed),
`endif
    .instr       (instr),
    .pc          (pc),
    .fill_valve  (fill_valve),
    .drain_valve (drain_valve),
    .motor_fwd   (motor_fwd),
    .motor_rev   (motor_rev),
    .loop_cnt    (loop_cnt),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  // Reference model: the machine is "active" while executing, "waiting" while
  // m_wait > 0, and "halted" after halt/illegal. Timers: 0 fill, 1 drain, 2 motor.
  int m_pc, m_loop, m_wait;
  int m_tmr [3];
  bit m_active, m_halted, m_err, m_rev;

  function automatic void model_reset();
    m_pc = 0; m_loop = 0; m_wait = 0;
    for (int i = 0; i < 3; i++) m_tmr[i] = 0;
    m_active = 0; m_halted = 0; m_err = 0; m_rev = 0;
  endfunction

  function automatic void model_clock();
    logic [15:0] w;
    int op, arg;
    bit ld [3];
    int val [3];
    if (abort) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 3; i++) begin ld[i] = 0; val[i] = 0; end
    if (m_active && m_wait == 0) begin
      w   = rom[m_pc];
      op  = int'(w[7:0]);
      arg = int'(w[15:8]);
      case (op)
        'h00: begin m_active = 0; m_halted = 1; end
        'h01: if (arg == 0) m_pc = (m_pc + 1) % 256; else m_wait = arg;
        'h02: begin ld[0] = 1; val[0] = arg; ld[1] = 1; m_pc = (m_pc + 1) % 256; end
        'h03: begin ld[1] = 1; val[1] = arg; ld[0] = 1; m_pc = (m_pc + 1) % 256; end
        'h04: begin ld[2] = 1; val[2] = arg; m_rev = 0; m_pc = (m_pc + 1) % 256; end
        'h05: begin ld[2] = 1; val[2] = arg; m_rev = 1; m_pc = (m_pc + 1) % 256; end
        'h11: begin m_loop = arg; m_pc = (m_pc + 1) % 256; end
        'h12: begin m_loop = (m_loop + 255) % 256; m_pc = (m_pc + 1) % 256; end
        'h21: m_pc = (m_loop == 0) ? arg : (m_pc + 1) % 256;
        'h22: m_pc = (m_loop != 0) ? arg : (m_pc + 1) % 256;
        default: begin
          if (ERR_ON_ILLEGAL) begin
            m_active = 0; m_halted = 1; m_err = 1;
            for (int i = 0; i < 3; i++) ld[i] = 1;
          end else begin
            m_pc = (m_pc + 1) % 256;
          end
        end
      endcase
    end else if (m_active) begin
      if (tick) begin
        m_wait--;
        if (m_wait == 0) m_pc = (m_pc + 1) % 256;
      end
    end else if (start) begin
      m_active = 1; m_halted = 0; m_err = 0; m_pc = START_PC;
    end
    for (int i = 0; i < 3; i++) begin
      if (ld[i]) m_tmr[i] = val[i];
      else if (tick && m_tmr[i] > 0) m_tmr[i]--;
    end
  endfunction

  initial model_reset();

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_clock();
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [7:0] e_pc, e_loop;
      logic e_fill, e_drain, e_fwd, e_rev, e_busy, e_done, e_err;
      e_pc    = 8'(m_pc);
      e_loop  = 8'(m_loop);
      e_fill  = m_tmr[0] != 0;
      e_drain = m_tmr[1] != 0;
      e_fwd   = m_tmr[2] != 0 && !m_rev;
      e_rev   = m_tmr[2] != 0 &&  m_rev;
      e_busy  = m_active;
      e_done  = m_halted && !m_err;
      e_err   = m_err;
      tests++;
      if (pc !== e_pc || loop_cnt !== e_loop || fill_valve !== e_fill ||
          drain_valve !== e_drain || motor_fwd !== e_fwd || motor_rev !== e_rev ||
          busy !== e_busy || done !== e_done || err !== e_err) begin
        failed++;
        $display("FAIL model_cmp t=%0t got pc=%0d loop=%0d fill=%b drain=%b fwd=%b rev=%b busy=%b done=%b err=%b, expected pc=%0d loop=%0d fill=%b drain=%b fwd=%b rev=%b busy=%b done=%b err=%b",
                 $time, pc, loop_cnt, fill_valve, drain_valve, motor_fwd, motor_rev, busy, done, err,
                 e_pc, e_loop, e_fill, e_drain, e_fwd, e_rev, e_busy, e_done, e_err);
      end
      tests++;
      if ((fill_valve && drain_valve) || (motor_fwd && motor_rev)) begin
        failed++;
        $display("FAIL exclusive t=%0t got fill/drain=%b%b fwd/rev=%b%b, expected no pair both high",
                 $time, fill_valve, drain_valve, motor_fwd, motor_rev);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  function automatic logic [15:0] rand_word();
    logic [7:0] op, arg;
    int k;
    k = $urandom_range(0, 21);
    arg = 8'($urandom_range(0, 12));
    case (k)
      0:           op = 8'h00;
      1, 2, 3, 21: begin op = 8'h01; arg = 8'($urandom_range(0, 5)); end
      4, 5:        op = 8'h02;
      6, 7:        op = 8'h03;
      8, 9:        op = 8'h04;
      10, 11:      op = 8'h05;
      12, 13:      begin op = 8'h11; arg = 8'($urandom_range(0, 3)); end
      14, 15:      op = 8'h12;
      16, 17:      begin op = 8'h21; arg = 8'($urandom_range(0, 40)); end
      18, 19:      begin op = 8'h22; arg = 8'($urandom_range(0, 40)); end
      default:     op = ($urandom_range(0, 1) == 0) ? 8'h7F : 8'h30;
    endcase
    return {arg, op};
  endfunction

  initial begin
    int fill_cnt, drain_cnt, fwd_bursts, fwd_bad, flen, rev_len, last_rev, ntick, rev_cnt;
    bit pf, pr, seen;

    clear_rom();
    repeat (2) @(negedge clk);
    check("reset_pc", pc, 0);
    check("reset_outputs", {fill_valve, drain_valve, motor_fwd, motor_rev, busy, done, err}, 0);
    check("reset_loop", loop_cnt, 0);
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    // Standard wash program.
    clear_rom();
    rom[2]  = 16'h6402; // fill 100
    rom[3]  = 16'h3201; // wait 50
    rom[4]  = 16'h0511; // set 5
    rom[5]  = 16'h1404; // fwd 20
    rom[6]  = 16'h0A01; // wait 10
    rom[7]  = 16'h1405; // rev 20
    rom[8]  = 16'h0A01; // wait 10
    rom[9]  = 16'h0012; // dec
    rom[10] = 16'h0522; // jnz 5
    rom[11] = 16'h6403; // release 100
    rom[12] = 16'h0000; // halt
    tick = 1'b1;
    pulse_start();
    fill_cnt = 0; drain_cnt = 0; fwd_bursts = 0; fwd_bad = 0; flen = 0;
    rev_len = 0; last_rev = 0; pf = 0; pr = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      fill_cnt  += int'(fill_valve);
      drain_cnt += int'(drain_valve);
      if (motor_fwd) flen++;
      else if (pf) begin
        fwd_bursts++;
        // Forward runs for the fwd cycle, 10 waiting cycles and the cycle
        // returning to RUN before reverse takes over: 12 cycles.
        if (flen != 12) fwd_bad++;
        flen = 0;
      end
      if (motor_rev) rev_len++;
      else if (pr) begin last_rev = rev_len; rev_len = 0; end
      pf = motor_fwd;
      pr = motor_rev;
    end
    check("std_fill_cycles", fill_cnt, 100);
    check("std_fwd_bursts", fwd_bursts, 5);
    check("std_fwd_burst_len_bad", fwd_bad, 0);
    check("std_last_rev_len", last_rev, 20);
    check("std_loop_end", loop_cnt, 0);
    check("std_done", done, 1);
    check("std_pc", pc, 12);
    check("std_drain_cycles", drain_cnt, 100);

    // set 0; dec; jz 40 -> wrap to FF, branch not taken.
    clear_rom();
    rom[2] = 16'h0011;
    rom[3] = 16'h0012;
    rom[4] = 16'h2821;
    pulse_start();
    repeat (6) @(negedge clk);
    check("dec_wrap_loop", loop_cnt, 255);
    check("jz_not_taken_pc", pc, 5);
    check("jz_halt_done", done, 1);

    // wait 0 then wait 3 with sparse ticks.
    clear_rom();
    rom[2] = 16'h0001;
    rom[3] = 16'h0301;
    tick = 1'b0;
    pulse_start();
    check("wait0_entry_pc", pc, 2);
    @(negedge clk);
    check("wait0_one_cycle_pc", pc, 3);
    ntick = 0; seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      tick = (c % 4 == 3);
      @(negedge clk);
      if (tick) ntick++;
      if (pc == 8'd4) seen = 1;
      else if (!busy) seen = 1;
    end
    tick = 1'b0;
    check("wait3_reached", int'(pc), 4);
    check("wait3_ticks", ntick, 3);
    tick = 1'b1;
    repeat (2) @(negedge clk);

    // fwd 20 then rev 5 back to back.
    clear_rom();
    rom[2] = 16'h1404;
    rom[3] = 16'h0505;
    pulse_start();
    @(negedge clk);
    check("fwd_on", {motor_fwd, motor_rev}, 2);
    @(negedge clk);
    check("rev_takes_over", {motor_fwd, motor_rev}, 1);
    rev_cnt = 1;
    repeat (10) begin
      @(negedge clk);
      rev_cnt += int'(motor_rev);
    end
    check("rev_len", rev_cnt, 5);

    // Illegal opcode while filling.
    clear_rom();
    rom[2] = 16'h3202;
    rom[3] = 16'h007F;
    pulse_start();
    @(negedge clk);
    check("illegal_pre_fill", fill_valve, 1);
    @(negedge clk);
    check("illegal_err", err, 1);
    check("illegal_fill_off", fill_valve, 0);
    check("illegal_done", done, 0);
    check("illegal_busy", busy, 0);
    pulse_start();
    check("restart_err_clear", err, 0);
    check("restart_pc", pc, 2);
    repeat (3) @(negedge clk);

    // Abort in the middle of a wait with the motor running.
    clear_rom();
    rom[2] = 16'h1E04;
    rom[3] = 16'h1401;
    pulse_start();
    repeat (5) @(negedge clk);
    check("abort_pre_motor", motor_fwd, 1);
    check("abort_pre_busy", busy, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_pc", pc, 0);
    check("abort_outputs", {fill_valve, drain_valve, motor_fwd, motor_rev, busy, done, err}, 0);
    check("abort_loop", loop_cnt, 0);

    // Asynchronous reset mid-RUN.
    clear_rom();
    rom[2] = 16'h3202;
    rom[3] = 16'h0321;
    pulse_start();
    repeat (3) @(negedge clk);
    check("rst_pre_busy", busy, 1);
    check("rst_pre_fill", fill_valve, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_pc", pc, 0);
    check("async_rst_outputs", {fill_valve, drain_valve, motor_fwd, motor_rev, busy, done, err}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Randomised programs and control pulses against the model.
    for (int r = 0; r < 4; r++) begin
      rom[0] = 16'h0000;
      rom[1] = 16'h0000;
      for (int i = 2; i < 256; i++) rom[i] = rand_word();
      for (int c = 0; c < 800; c++) begin
        tick  = ($urandom_range(0, 2) != 0);
        start = ($urandom_range(0, 15) == 0);
        abort = ($urandom_range(0, 63) == 0);
        @(negedge clk);
      end
      start = 1'b0;
      abort = 1'b0;
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
